// File: rtl/usbdev_in_pkt_sched.sv
// usbdev_in_pkt_sched: IN-packet scheduler for the USB device IN path.
// Holds per-endpoint packet configuration (buffer id, size, ready), snapshots
// the scheduled packet when an IN transaction starts, serves payload bytes
// from the shared packet SRAM, and retires or retains the packet when the
// transaction ends or rolls back.
module usbdev_in_pkt_sched #(
    parameter int unsigned NumInEps         = 12,
    parameter int unsigned MaxInPktSizeByte = 64,
    parameter int unsigned NumBuffers       = 32,
    localparam int unsigned PktW            = $clog2(MaxInPktSizeByte),
    localparam int unsigned BufW            = $clog2(NumBuffers)
) (
    input  logic                     clk_48mhz_i,
    input  logic                     rst_i,
    input  logic                     link_reset_i,

    // Software packet configuration
    input  logic                     cfg_we_i,
    input  logic [3:0]               cfg_ep_i,
    input  logic [BufW-1:0]          cfg_buf_i,
    input  logic [PktW:0]            cfg_size_i,
    input  logic                     cfg_rdy_i,
    output logic                     cfg_reject_o,
    input  logic [NumInEps-1:0]      sent_clr_i,
    output logic [NumInEps-1:0]      sent_o,
    output logic                     pkt_sent_o,
    output logic [NumInEps-1:0]      rdy_o,

    // IN protocol engine endpoint interface
    input  logic                     in_xact_starting_i,
    input  logic [3:0]               in_xact_start_ep_i,
    input  logic [PktW-1:0]          in_ep_get_addr_i,
    input  logic                     in_ep_xact_end_i,
    input  logic                     in_ep_rollback_i,
    output logic [NumInEps-1:0]      in_ep_has_data_o,
    output logic [NumInEps-1:0]      in_ep_data_done_o,
    output logic [7:0]               in_ep_data_o,

    // Packet SRAM read port
    output logic                     mem_req_o,
    output logic [BufW+PktW-3:0]     mem_addr_o,
    input  logic [31:0]              mem_rdata_i
);

    // Per-endpoint configuration
    logic [NumInEps-1:0] rdy_q, rdy_d;
    logic [BufW-1:0]     buf_q  [NumInEps];
    logic [BufW-1:0]     buf_d  [NumInEps];
    logic [PktW:0]       size_q [NumInEps];
    logic [PktW:0]       size_d [NumInEps];

    // Snapshot of the packet being served
    logic [3:0]          cur_ep_q, cur_ep_d;
    logic [BufW-1:0]     cur_buf_q, cur_buf_d;
    logic [PktW:0]       cur_size_q, cur_size_d;

    // Transaction flags and pulses
    logic                in_flight_q, in_flight_d;
    logic                start_d1_q, start_d1_d;
    logic [NumInEps-1:0] sent_q, sent_d;
    logic                cfg_reject_q, cfg_reject_d;
    logic                pkt_sent_q, pkt_sent_d;

    // Read-data alignment: byte lane and valid follow the SRAM latency
    logic [1:0]          lane_q, lane_d;
    logic                rd_vld_q, rd_vld_d;

    // Event decode
    logic cfg_ep_valid, start_ep_valid;
    logic cfg_blocked, cfg_accept;
    logic start_rdy, retire, rollback_ok;

    // Decode the qualifying events for this cycle
    always_comb begin
        cfg_ep_valid   = ({1'b0, cfg_ep_i} < 5'(NumInEps));
        start_ep_valid = ({1'b0, in_xact_start_ep_i} < 5'(NumInEps));
        cfg_blocked    = cfg_we_i && cfg_ep_valid && in_flight_q && (cfg_ep_i == cur_ep_q);
        cfg_accept     = cfg_we_i && cfg_ep_valid && !cfg_blocked;
        start_rdy      = in_xact_starting_i && start_ep_valid && rdy_q[in_xact_start_ep_i];
        retire         = in_ep_xact_end_i && in_flight_q;
        // A rollback right after a start refers to the previous transaction.
        rollback_ok    = in_ep_rollback_i && !start_d1_q;
    end

    // Next-state computation for configuration, snapshot and flags
    always_comb begin
        // NOTE: every variable gets its hold value first, so partial updates
        // below never infer a latch; combinational logic uses blocking '='.
        rdy_d        = rdy_q;
        buf_d        = buf_q;
        size_d       = size_q;
        cur_ep_d     = cur_ep_q;
        cur_buf_d    = cur_buf_q;
        cur_size_d   = cur_size_q;
        in_flight_d  = in_flight_q;
        sent_d       = sent_q & ~sent_clr_i;
        start_d1_d   = in_xact_starting_i;
        cfg_reject_d = cfg_blocked;
        pkt_sent_d   = retire;
        lane_d       = in_ep_get_addr_i[1:0];
        rd_vld_d     = in_flight_q;

        if (cfg_accept) begin
            rdy_d[cfg_ep_i]  = cfg_rdy_i;
            buf_d[cfg_ep_i]  = cfg_buf_i;
            size_d[cfg_ep_i] = cfg_size_i;
        end

        // Retire uses the old snapshot endpoint even if a start lands now.
        if (retire) begin
            rdy_d[cur_ep_q]  = 1'b0;
            sent_d[cur_ep_q] = 1'b1;
        end

        if (retire || rollback_ok) begin
            in_flight_d = 1'b0;
        end

        // A start decides in_flight last so it wins over a same-cycle retire.
        if (in_xact_starting_i) begin
            in_flight_d = start_rdy;
            if (start_rdy) begin
                cur_ep_d   = in_xact_start_ep_i;
                cur_buf_d  = buf_q[in_xact_start_ep_i];
                cur_size_d = size_q[in_xact_start_ep_i];
            end
        end

        // Bus reset drops every pending packet but keeps buffer setup.
        if (link_reset_i) begin
            rdy_d       = '0;
            in_flight_d = 1'b0;
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk_48mhz_i or posedge rst_i) begin
        if (rst_i) begin
            // NOTE: the per-endpoint table is a small flop array, not SRAM, so
            // it is reset along with everything else to keep readback defined.
            for (int e = 0; e < NumInEps; e++) begin
                buf_q[e]  <= '0;
                size_q[e] <= '0;
            end
            rdy_q        <= '0;
            cur_ep_q     <= '0;
            cur_buf_q    <= '0;
            cur_size_q   <= '0;
            in_flight_q  <= 1'b0;
            start_d1_q   <= 1'b0;
            sent_q       <= '0;
            cfg_reject_q <= 1'b0;
            pkt_sent_q   <= 1'b0;
            lane_q       <= '0;
            rd_vld_q     <= 1'b0;
        end else begin
            buf_q        <= buf_d;
            size_q       <= size_d;
            rdy_q        <= rdy_d;
            cur_ep_q     <= cur_ep_d;
            cur_buf_q    <= cur_buf_d;
            cur_size_q   <= cur_size_d;
            in_flight_q  <= in_flight_d;
            start_d1_q   <= start_d1_d;
            sent_q       <= sent_d;
            cfg_reject_q <= cfg_reject_d;
            pkt_sent_q   <= pkt_sent_d;
            lane_q       <= lane_d;
            rd_vld_q     <= rd_vld_d;
        end
    end

    // Per-endpoint out-of-data: only the snapshot endpoint can have data left
    always_comb begin
        in_ep_data_done_o = '1;
        for (int e = 0; e < NumInEps; e++) begin
            if (4'(e) == cur_ep_q) begin
                in_ep_data_done_o[e] = ({1'b0, in_ep_get_addr_i} >= cur_size_q);
            end
        end
    end

    // Byte-lane select on the SRAM word returned one cycle after the request
    always_comb begin
        in_ep_data_o = '0;
        if (rd_vld_q) begin
            case (lane_q)
                2'd0:    in_ep_data_o = mem_rdata_i[7:0];
                2'd1:    in_ep_data_o = mem_rdata_i[15:8];
                2'd2:    in_ep_data_o = mem_rdata_i[23:16];
                default: in_ep_data_o = mem_rdata_i[31:24];
            endcase
        end
    end

    assign mem_req_o        = in_flight_q;
    assign mem_addr_o       = {cur_buf_q, in_ep_get_addr_i[PktW-1:2]};
    assign rdy_o            = rdy_q;
    assign in_ep_has_data_o = rdy_q;
    assign sent_o           = sent_q;
    assign cfg_reject_o     = cfg_reject_q;
    assign pkt_sent_o       = pkt_sent_q;

endmodule

// File: tb/tb_usbdev_in_pkt_sched.sv
// Directed testbench for usbdev_in_pkt_sched with an SRAM model and a
// scoreboard queue for payload bytes.
module tb_usbdev_in_pkt_sched;

    localparam int NumInEps = 12;
    localparam int PktW     = 6;
    localparam int BufW     = 5;

    logic                 clk_48mhz_i = 1'b0;
    logic                 rst_i;
    logic                 link_reset_i;
    logic                 cfg_we_i;
    logic [3:0]           cfg_ep_i;
    logic [BufW-1:0]      cfg_buf_i;
    logic [PktW:0]        cfg_size_i;
    logic                 cfg_rdy_i;
    logic                 cfg_reject_o;
    logic [NumInEps-1:0]  sent_clr_i;
    logic [NumInEps-1:0]  sent_o;
    logic                 pkt_sent_o;
    logic [NumInEps-1:0]  rdy_o;
    logic                 in_xact_starting_i;
    logic [3:0]           in_xact_start_ep_i;
    logic [PktW-1:0]      in_ep_get_addr_i;
    logic                 in_ep_xact_end_i;
    logic                 in_ep_rollback_i;
    logic [NumInEps-1:0]  in_ep_has_data_o;
    logic [NumInEps-1:0]  in_ep_data_done_o;
    logic [7:0]           in_ep_data_o;
    logic                 mem_req_o;
    logic [BufW+PktW-3:0] mem_addr_o;
    logic [31:0]          mem_rdata_i = '0;

    int errors = 0;
    int checks = 0;
    logic [7:0]  exp_q [$];
    logic [31:0] sram [512];

    usbdev_in_pkt_sched dut (
        .clk_48mhz_i        (clk_48mhz_i),
        .rst_i              (rst_i),
        .link_reset_i       (link_reset_i),
        .cfg_we_i           (cfg_we_i),
        .cfg_ep_i           (cfg_ep_i),
        .cfg_buf_i          (cfg_buf_i),
        .cfg_size_i         (cfg_size_i),
        .cfg_rdy_i          (cfg_rdy_i),
        .cfg_reject_o       (cfg_reject_o),
        .sent_clr_i         (sent_clr_i),
        .sent_o             (sent_o),
        .pkt_sent_o         (pkt_sent_o),
        .rdy_o              (rdy_o),
        .in_xact_starting_i (in_xact_starting_i),
        .in_xact_start_ep_i (in_xact_start_ep_i),
        .in_ep_get_addr_i   (in_ep_get_addr_i),
        .in_ep_xact_end_i   (in_ep_xact_end_i),
        .in_ep_rollback_i   (in_ep_rollback_i),
        .in_ep_has_data_o   (in_ep_has_data_o),
        .in_ep_data_done_o  (in_ep_data_done_o),
        .in_ep_data_o       (in_ep_data_o),
        .mem_req_o          (mem_req_o),
        .mem_addr_o         (mem_addr_o),
        .mem_rdata_i        (mem_rdata_i)
    );

    always #10 clk_48mhz_i = ~clk_48mhz_i;

    // Reference byte content at flat byte index buf*64 + offset
    function automatic logic [7:0] pattern(input int idx);
        return 8'((idx * 37 + 11) & 255);
    endfunction

    // SRAM model: one-cycle read latency
    always @(posedge clk_48mhz_i) begin
        if (mem_req_o) mem_rdata_i <= sram[mem_addr_o];
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk_48mhz_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cfg(input int ep, input int b, input int sz, input bit r);
        cfg_we_i   = 1'b1;
        cfg_ep_i   = 4'(ep);
        cfg_buf_i  = 5'(b);
        cfg_size_i = 7'(sz);
        cfg_rdy_i  = r;
        tick();
        cfg_we_i   = 1'b0;
    endtask

    task automatic start(input int ep);
        in_xact_starting_i = 1'b1;
        in_xact_start_ep_i = 4'(ep);
        tick();
        in_xact_starting_i = 1'b0;
    endtask

    task automatic retire_pkt(input string tag, input logic [NumInEps-1:0] exp_sent);
        in_ep_xact_end_i = 1'b1;
        tick();
        in_ep_xact_end_i = 1'b0;
        chk({tag, "_pkt_sent"}, pkt_sent_o, 1'b1);
        chk({tag, "_sent"}, sent_o, exp_sent);
        tick();
        chk({tag, "_pkt_sent_off"}, pkt_sent_o, 1'b0);
    endtask

    // Walk get_addr from 0 to last; expected bytes go through the scoreboard.
    task automatic serve(input int b, input int size, input int ep, input int last);
        logic [NumInEps-1:0] exp_done;
        for (int a = 0; a <= last; a++) begin
            in_ep_get_addr_i = 6'(a);
            #1;
            chk("mem_addr", mem_addr_o, 64'(b * 16 + a / 4));
            exp_done = '1;
            if (a < size) exp_done[ep] = 1'b0;
            chk("data_done", in_ep_data_done_o, exp_done);
            exp_q.push_back(pattern(b * 64 + a));
            tick();
            chk("payload", in_ep_data_o, exp_q.pop_front());
        end
        in_ep_get_addr_i = '0;
    endtask

    task automatic clear_sent(input logic [NumInEps-1:0] mask);
        sent_clr_i = mask;
        tick();
        sent_clr_i = '0;
    endtask

    initial begin
        for (int w = 0; w < 512; w++)
            for (int k = 0; k < 4; k++)
                sram[w][8*k +: 8] = pattern(w * 4 + k);

        rst_i = 1'b1; link_reset_i = 1'b0; cfg_we_i = 1'b0; cfg_ep_i = '0;
        cfg_buf_i = '0; cfg_size_i = '0; cfg_rdy_i = 1'b0; sent_clr_i = '0;
        in_xact_starting_i = 1'b0; in_xact_start_ep_i = '0; in_ep_get_addr_i = '0;
        in_ep_xact_end_i = 1'b0; in_ep_rollback_i = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst_rdy", rdy_o, 12'h000);
        chk("rst_has_data", in_ep_has_data_o, 12'h000);
        chk("rst_sent", sent_o, 12'h000);
        chk("rst_done", in_ep_data_done_o, 12'hFFF);
        chk("rst_mem_req", mem_req_o, 1'b0);
        chk("rst_data", in_ep_data_o, 8'h00);
        chk("rst_reject", cfg_reject_o, 1'b0);
        chk("rst_pkt_sent", pkt_sent_o, 1'b0);
        rst_i = 1'b0;
        tick();

        // Normal packet on EP2: buf 5, 10 bytes
        cfg(2, 5, 10, 1'b1);
        chk("t1_rdy", rdy_o, 12'h004);
        chk("t1_has_data", in_ep_has_data_o, 12'h004);
        chk("t1_reject", cfg_reject_o, 1'b0);
        start(2);
        chk("t1_mem_req", mem_req_o, 1'b1);
        serve(5, 10, 2, 10);
        retire_pkt("t1", 12'h004);
        chk("t1_rdy_after", rdy_o, 12'h000);
        chk("t1_mem_req_after", mem_req_o, 1'b0);
        clear_sent(12'h004);
        chk("t1_sent_clr", sent_o, 12'h000);

        // Rollback keeps the packet; the next start serves it again from 0
        cfg(2, 7, 6, 1'b1);
        start(2);
        serve(7, 6, 2, 3);
        in_ep_rollback_i = 1'b1;
        tick();
        in_ep_rollback_i = 1'b0;
        chk("t2_in_flight", mem_req_o, 1'b0);
        chk("t2_rdy", rdy_o, 12'h004);
        chk("t2_sent", sent_o, 12'h000);
        chk("t2_pkt_sent", pkt_sent_o, 1'b0);
        start(2);
        serve(7, 6, 2, 6);
        retire_pkt("t2", 12'h004);
        clear_sent(12'h004);

        // Zero-length packet on EP4
        cfg(4, 9, 0, 1'b1);
        start(4);
        chk("t3_done", in_ep_data_done_o, 12'hFFF);
        retire_pkt("t3", 12'h010);
        chk("t3_rdy", rdy_o, 12'h000);
        clear_sent(12'h010);

        // Config write to the in-flight endpoint is rejected
        cfg(2, 3, 8, 1'b1);
        start(2);
        cfg(2, 11, 20, 1'b1);
        chk("t4_reject", cfg_reject_o, 1'b1);
        tick();
        chk("t4_reject_off", cfg_reject_o, 1'b0);
        serve(3, 8, 2, 8);
        retire_pkt("t4a", 12'h004);
        cfg(2, 11, 20, 1'b1);
        chk("t4_accept", cfg_reject_o, 1'b0);
        chk("t4_rdy", rdy_o, 12'h004);
        start(2);
        serve(11, 20, 2, 20);
        retire_pkt("t4b", 12'h004);
        clear_sent(12'h004);

        // Rollback right after start is ignored; the following one is not
        cfg(1, 2, 4, 1'b1);
        start(1);
        in_ep_rollback_i = 1'b1;
        tick();
        chk("t5_ignored", mem_req_o, 1'b1);
        tick();
        in_ep_rollback_i = 1'b0;
        chk("t5_cleared", mem_req_o, 1'b0);
        chk("t5_rdy", rdy_o, 12'h002);

        // Retire with same-bit sent clear, plus a config write elsewhere
        cfg(3, 4, 2, 1'b1);
        start(3);
        in_ep_xact_end_i = 1'b1;
        sent_clr_i = 12'h008;
        cfg_we_i = 1'b1; cfg_ep_i = 4'd5; cfg_buf_i = 5'd6; cfg_size_i = 7'd3; cfg_rdy_i = 1'b1;
        tick();
        in_ep_xact_end_i = 1'b0; sent_clr_i = '0; cfg_we_i = 1'b0;
        chk("t6_sent_wins", sent_o, 12'h008);
        chk("t6_rdy", rdy_o, 12'h022);
        chk("t6_pkt_sent", pkt_sent_o, 1'b1);
        link_reset_i = 1'b1;
        tick();
        link_reset_i = 1'b0;
        chk("t6_link_rdy", rdy_o, 12'h000);
        chk("t6_link_has_data", in_ep_has_data_o, 12'h000);
        chk("t6_link_sent", sent_o, 12'h008);

        // Simultaneous start (EP7) and retire (EP6)
        cfg(6, 1, 4, 1'b1);
        cfg(7, 13, 3, 1'b1);
        start(6);
        in_ep_xact_end_i = 1'b1;
        in_xact_starting_i = 1'b1;
        in_xact_start_ep_i = 4'd7;
        tick();
        in_ep_xact_end_i = 1'b0;
        in_xact_starting_i = 1'b0;
        chk("t7_in_flight", mem_req_o, 1'b1);
        chk("t7_rdy", rdy_o, 12'h080);
        chk("t7_sent", sent_o, 12'h048);
        chk("t7_pkt_sent", pkt_sent_o, 1'b1);
        serve(13, 3, 7, 3);
        retire_pkt("t7", 12'h0C8);

        // Reset in the middle of a transaction
        cfg(0, 2, 5, 1'b1);
        start(0);
        in_ep_xact_end_i = 1'b1;
        rst_i = 1'b1;
        #1;
        chk("t8_rdy", rdy_o, 12'h000);
        chk("t8_sent", sent_o, 12'h000);
        chk("t8_mem_req", mem_req_o, 1'b0);
        chk("t8_done", in_ep_data_done_o, 12'hFFF);
        chk("t8_data", in_ep_data_o, 8'h00);
        tick();
        chk("t8_pkt_sent", pkt_sent_o, 1'b0);
        chk("t8_reject", cfg_reject_o, 1'b0);
        in_ep_xact_end_i = 1'b0;
        rst_i = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
